// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator with trap > redirect > sequential priority and a circular RAS.
// All state is registered (1-cycle); fetch_pc is held while fetch_valid & ~fetch_ready, and stall masks fetch_valid.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0100_0000),
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            misalign_err
);

  localparam int              PTR_W      = $clog2(RAS_DEPTH);
  localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic             misalign_q;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             fire;
  logic             redirect_aligned;
  logic             ras_nonempty;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;
  logic [XLEN-1:0]  ret_addr;

  assign fetch_valid      = valid_q & ~stall;
  assign fetch_pc         = pc_q;
  assign fire             = fetch_valid & fetch_ready;
  assign redirect_aligned = (redirect_pc & ALIGN_MASK) == '0;
  assign ras_nonempty     = cnt_q != '0;
  assign ret_addr         = pc_q + STEP;
  assign top_inc          = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign top_dec          = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);

  // A trap flushes the stack, so push/pop only take effect without one.
  // push&pop on an empty stack degrades to a plain push.
  assign do_swap = ~trap_valid & ras_push & ras_pop & ras_nonempty;
  assign do_push = ~trap_valid & ras_push & ~do_swap;
  assign do_pop  = ~trap_valid & ras_pop & ~ras_push & ras_nonempty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      top_q      <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= 1'b1;
      misalign_q <= ~trap_valid & redirect_valid & ~redirect_aligned;

      // A rejected redirect still blocks the sequential increment.
      if (trap_valid) begin
        pc_q <= trap_vec & ~ALIGN_MASK;
      end else if (redirect_valid) begin
        if (redirect_aligned) pc_q <= redirect_pc;
      end else if (fire) begin
        pc_q <= pc_q + STEP;
      end

      if (trap_valid) begin
        cnt_q <= '0;
      end else if (do_push) begin
        top_q <= top_inc;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop) begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push)      ras_mem[top_inc] <= ret_addr;
      else if (do_swap) ras_mem[top_q]   <= ret_addr;
    end
  end

  assign ras_top      = ras_nonempty ? ras_mem[top_q] : '0;
  assign ras_empty    = ~ras_nonempty;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready, redirect_valid, trap_valid, ras_push, ras_pop;
  logic [31:0] redirect_pc, trap_vec;
  logic        fetch_valid, ras_empty, misalign_err;
  logic [31:0] fetch_pc, ras_top;

  int n_err = 0;
  int n_chk = 0;

  // behavioural model state
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_ras[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_top(ras_top), .ras_empty(ras_empty), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model for the inputs currently applied.
  task automatic settle();
    #1;
    chk("fetch_valid", 32'(fetch_valid), 32'(m_valid & ~stall));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_top", ras_top, (m_ras.size() == 0) ? 32'h0 : m_ras[$]);
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  // Clock edge: update the model from the applied inputs, then return at the falling edge.
  task automatic adv();
    logic fire;
    @(posedge clk);
    if (rst) begin
      m_pc = RV; m_valid = 1'b0; m_mis = 1'b0; m_ras.delete();
    end else begin
      fire    = m_valid & ~stall & fetch_ready;
      m_valid = 1'b1;
      m_mis   = 1'b0;
      if (trap_valid) begin
        m_pc = {trap_vec[31:2], 2'b00};
        m_ras.delete();
      end else begin
        if (ras_push && ras_pop && m_ras.size() > 0) begin
          m_ras[m_ras.size()-1] = m_pc + 4;
        end else if (ras_push) begin
          m_ras.push_back(m_pc + 4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (ras_pop && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
        if (redirect_valid) begin
          if (redirect_pc % 4 == 0) m_pc = redirect_pc;
          else m_mis = 1'b1;
        end else if (fire) begin
          m_pc = m_pc + 4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; trap_valid = 0; ras_push = 0; ras_pop = 0;
  endtask

  task automatic push_from(input logic [31:0] addr);
    redirect_valid = 1; redirect_pc = addr; settle(); adv();
    redirect_valid = 0; ras_push = 1; settle(); adv();
    ras_push = 0;
  endtask

  initial begin
    rst = 1; idle_inputs(); fetch_ready = 1; redirect_pc = '0; trap_vec = '0;
    // 1: reset then sequential fetch
    adv();
    settle(); chk("rst_fv", 32'(fetch_valid), 32'h0);
    adv();
    rst = 0;
    settle(); chk("rel_fv", 32'(fetch_valid), 32'h0); chk("rel_pc", fetch_pc, RV);
    adv();
    settle(); chk("seq0", fetch_pc, 32'h0100_0000); chk("seq0_fv", 32'(fetch_valid), 32'h1);
    adv();
    settle(); chk("seq1", fetch_pc, 32'h0100_0004); adv();
    settle(); chk("seq2", fetch_pc, 32'h0100_0008);
    // 2: backpressure and stall
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("bp_pc", fetch_pc, 32'h0100_0008); chk("bp_fv", 32'(fetch_valid), 32'h1); adv();
    end
    stall = 1;
    settle(); chk("stall_fv", 32'(fetch_valid), 32'h0); adv();
    settle(); chk("stall_pc", fetch_pc, 32'h0100_0008);
    stall = 0; fetch_ready = 1;
    settle(); adv();
    settle(); chk("after_stall", fetch_pc, 32'h0100_000C);
    // 3: trap beats redirect; misaligned redirect rejected
    fetch_ready = 0;
    trap_valid = 1; trap_vec = 32'h0100_0103; redirect_valid = 1; redirect_pc = 32'h0100_0200;
    settle(); adv(); idle_inputs();
    settle(); chk("trap_pc", fetch_pc, 32'h0100_0100); chk("trap_mis", 32'(misalign_err), 32'h0);
    redirect_valid = 1; redirect_pc = 32'h0100_0202;
    settle(); adv(); idle_inputs();
    settle(); chk("mis_pc", fetch_pc, 32'h0100_0100); chk("mis_pulse", 32'(misalign_err), 32'h1); adv();
    settle(); chk("mis_clear", 32'(misalign_err), 32'h0);
    // 4: wrap
    fetch_ready = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    settle(); adv(); redirect_valid = 0;
    settle(); chk("wrap_hi", fetch_pc, 32'hFFFF_FFFC); adv();
    settle(); chk("wrap_lo", fetch_pc, 32'h0);
    // 5: RAS
    fetch_ready = 0;
    for (int i = 1; i <= 5; i++) push_from(32'(i * 16));
    settle(); chk("ras_5push", ras_top, 32'h54);
    ras_pop = 1;
    settle(); adv(); settle(); chk("pop1", ras_top, 32'h44);
    adv(); settle(); chk("pop2", ras_top, 32'h34);
    adv(); settle(); chk("pop3", ras_top, 32'h24);
    adv(); settle(); chk("pop4_empty", 32'(ras_empty), 32'h1); chk("pop4_top", ras_top, 32'h0);
    adv(); settle(); chk("pop5_empty", 32'(ras_empty), 32'h1);
    ras_pop = 0;
    push_from(32'h10); push_from(32'h20);
    redirect_valid = 1; redirect_pc = 32'h80; settle(); adv(); redirect_valid = 0;
    ras_push = 1; ras_pop = 1; settle(); chk("swap_pre", ras_top, 32'h24); adv();
    ras_push = 0;
    settle(); chk("swap_top", ras_top, 32'h84); adv();
    settle(); chk("swap_cnt", ras_top, 32'h14); adv();
    settle(); chk("swap_empty", 32'(ras_empty), 32'h1);
    ras_pop = 0;
    // 6: mid-operation reset
    push_from(32'h40);
    rst = 1; redirect_valid = 1; redirect_pc = 32'h0100_0202; ras_push = 1;
    settle(); adv();
    rst = 0; idle_inputs();
    settle();
    chk("mrst_pc", fetch_pc, RV); chk("mrst_fv", 32'(fetch_valid), 32'h0);
    chk("mrst_empty", 32'(ras_empty), 32'h1); chk("mrst_mis", 32'(misalign_err), 32'h0);
    adv();
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(99) == 0);
      stall          = ($urandom_range(4) == 0);
      fetch_ready    = ($urandom_range(2) != 0);
      trap_valid     = ($urandom_range(29) == 0);
      trap_vec       = $urandom();
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom();
      if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
      ras_push       = ($urandom_range(3) == 0);
      ras_pop        = ($urandom_range(3) == 0);
      settle(); adv();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
